// File: rtl/branch_pc_unit.sv
// branch_pc_unit: branch/jump resolution, next-PC generation and the PC register
// for the single-cycle RV32I core. It consumes br_less/br_equal from the branch
// comparator and returns br_un to it. A misaligned taken target parks the core
// in TRAP until reset.
// Optional build macro: BRANCH_STATS_EN adds branch/jump event counters.
// Only XLEN = 32 is supported.
module branch_pc_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [2:0]      funct3,
  input  logic            br_less,
  input  logic            br_equal,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  output logic            br_un,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_four,
  output logic            br_taken,
  output logic [XLEN-1:0] pc_next,
  output logic            trap,
  output logic [XLEN-1:0] trap_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     br_count,
  output logic [31:0]     br_taken_count,
  output logic [31:0]     jump_count
`endif
);

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;

  logic            br_cond;
  logic            taken_raw;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            advance;

  // The signed/unsigned choice is encoded in funct3[1] for all branch types.
  assign br_un   = funct3[1];
  assign pc_four = pc_q + XLEN'(4);

  // Branch condition decode from the comparator flags.
  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      3'b000:         br_cond = br_equal;
      3'b001:         br_cond = !br_equal;
      3'b100, 3'b110: br_cond = br_less;
      3'b101, 3'b111: br_cond = !br_less;
      default:        br_cond = 1'b0;
    endcase
  end

  // Resolve control transfer with JALR > JAL > branch priority.
  always_comb begin
    taken_raw = 1'b0;
    target    = pc_q + imm;
    if (is_jalr) begin
      taken_raw = 1'b1;
      target    = (rs1_data + imm) & ~XLEN'(1);
    end else if (is_jal) begin
      taken_raw = 1'b1;
    end else if (is_branch) begin
      taken_raw = br_cond;
    end
  end

  // Nothing is taken once trapped; the PC register is frozen there anyway.
  assign br_taken   = taken_raw && (state_q == RUN);
  assign pc_next    = br_taken ? target : pc_four;
  assign misaligned = br_taken && (target[1:0] != 2'b00);
  assign advance    = (state_q == RUN) && !stall && !misaligned;

  // Next-state logic for the RUN/TRAP machine and the PC registers.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    trap_pc_d = trap_pc_q;
    case (state_q)
      RUN: begin
        if (!stall) begin
          if (misaligned) begin
            trap_pc_d = pc_q;
            state_d   = TRAP;
          end else begin
            pc_d = pc_next;
          end
        end
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: state_d = RUN;
    endcase
  end

  // State and PC registers; reset dominates stall and any trap condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      trap_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      trap_pc_q <= trap_pc_d;
    end
  end

  assign pc      = pc_q;
  assign trap    = (state_q == TRAP);
  assign trap_pc = trap_pc_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] br_taken_count_q, br_taken_count_d;
  logic [31:0] jump_count_q, jump_count_d;

  // Count only instructions that actually retire (not stalled, not trapping).
  always_comb begin
    br_count_d       = br_count_q;
    br_taken_count_d = br_taken_count_q;
    jump_count_d     = jump_count_q;
    if (advance) begin
      if (is_jalr || is_jal) begin
        jump_count_d = jump_count_q + 32'd1;
      end else if (is_branch) begin
        br_count_d = br_count_q + 32'd1;
        if (br_taken) begin
          br_taken_count_d = br_taken_count_q + 32'd1;
        end
      end
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q       <= '0;
      br_taken_count_q <= '0;
      jump_count_q     <= '0;
    end else begin
      br_count_q       <= br_count_d;
      br_taken_count_q <= br_taken_count_d;
      jump_count_q     <= jump_count_d;
    end
  end

  assign br_count       = br_count_q;
  assign br_taken_count = br_taken_count_q;
  assign jump_count     = jump_count_q;
`else
  // advance only feeds the optional counters.
  logic unused_advance;
  assign unused_advance = advance;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: each stimulus cycle pushes the
// hand-computed outputs expected during that cycle; a negedge monitor pops
// and compares them.
module tb_branch_pc_unit;

  logic        clk;
  logic        rst, stall, is_branch, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic        br_less, br_equal;
  logic [31:0] imm, rs1_data;
  logic        br_un, br_taken, trap;
  logic [31:0] pc, pc_four, pc_next, trap_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_count, br_taken_count, jump_count;
`endif

  branch_pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .is_branch(is_branch),
    .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3),
    .br_less(br_less), .br_equal(br_equal), .imm(imm), .rs1_data(rs1_data),
    .br_un(br_un), .pc(pc), .pc_four(pc_four), .br_taken(br_taken),
    .pc_next(pc_next), .trap(trap), .trap_pc(trap_pc)
`ifdef BRANCH_STATS_EN
    , .br_count(br_count), .br_taken_count(br_taken_count),
    .jump_count(jump_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] pc, nx, tpc;
    logic        tk, trap, un;
    bit          cnt;
    logic [31:0] bc, btc, jc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_id  = 0;

  bit          cnt_en = 1'b0;
  logic [31:0] cnt_bc, cnt_btc, cnt_jc;

  function automatic void cmp(string name, int id, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, id, act, req);
    end
  endfunction

  // Monitor: compare whatever the stimulus queued for this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("pc",       e.id, pc,       e.pc);
      cmp("pc_next",  e.id, pc_next,  e.nx);
      cmp("br_taken", e.id, {31'd0, br_taken}, {31'd0, e.tk});
      cmp("trap",     e.id, {31'd0, trap},     {31'd0, e.trap});
      cmp("trap_pc",  e.id, trap_pc,  e.tpc);
      cmp("br_un",    e.id, {31'd0, br_un},    {31'd0, e.un});
      cmp("pc_four",  e.id, pc_four,  e.pc + 32'd4);
`ifdef BRANCH_STATS_EN
      if (e.cnt) begin
        cmp("br_count",       e.id, br_count,       e.bc);
        cmp("br_taken_count", e.id, br_taken_count, e.btc);
        cmp("jump_count",     e.id, jump_count,     e.jc);
      end
`endif
    end
  end

  task automatic step(input logic r, s, b, j, jr, input logic [2:0] f3,
                      input logic lt, eq, input logic [31:0] im, rs,
                      input bit chk, input logic [31:0] epc, input logic etk,
                      input logic [31:0] enx, input logic etr, input logic [31:0] etpc);
    exp_t e;
    rst = r; stall = s; is_branch = b; is_jal = j; is_jalr = jr;
    funct3 = f3; br_less = lt; br_equal = eq; imm = im; rs1_data = rs;
    step_id++;
    if (chk) begin
      e.id = step_id; e.pc = epc; e.nx = enx; e.tpc = etpc;
      e.tk = etk; e.trap = etr; e.un = f3[1];
      e.cnt = cnt_en; e.bc = cnt_bc; e.btc = cnt_btc; e.jc = cnt_jc;
      exp_q.push_back(e);
    end
    cnt_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_counts(input logic [31:0] bc, btc, jc);
    cnt_en = 1'b1; cnt_bc = bc; cnt_btc = btc; cnt_jc = jc;
  endtask

  initial begin
    //   rst stl br jal jlr f3     lt eq imm            rs1            chk pc             tk nx             trp tpc
    // Reset with stall and JAL asserted, then free-run 0 -> 4 -> 8.
    step(1, 1, 0, 1, 0, 3'b000, 0, 0, 32'h8,         32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0);
    step(1, 1, 0, 1, 0, 3'b000, 0, 0, 32'h8,         32'h0,         1, 32'h0,         1, 32'h8,         0, 32'h0);
    step(0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,         32'h0,         1, 32'h0,         0, 32'h4,         0, 32'h0);
    step(0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,         32'h0,         1, 32'h4,         0, 32'h8,         0, 32'h0);
    step(0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,         32'h0,         1, 32'h8,         0, 32'hC,         0, 32'h0);
    // JAL to 0x100, then BLTU taken, BGE not taken.
    step(0, 0, 0, 1, 0, 3'b000, 0, 0, 32'hF4,        32'h0,         1, 32'hC,         1, 32'h100,       0, 32'h0);
    step(0, 0, 1, 0, 0, 3'b110, 1, 0, 32'h20,        32'h0,         1, 32'h100,       1, 32'h120,       0, 32'h0);
    step(0, 0, 1, 0, 0, 3'b101, 1, 0, 32'h20,        32'h0,         1, 32'h120,       0, 32'h124,       0, 32'h0);
    step(0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,         32'h0,         1, 32'h124,       0, 32'h128,       0, 32'h0);
    // Backward JAL to 0x40, then stalled BEQ taken.
    step(0, 0, 0, 1, 0, 3'b000, 0, 0, 32'hFFFF_FF18, 32'h0,         1, 32'h128,       1, 32'h40,        0, 32'h0);
    for (int i = 0; i < 3; i++)
      step(0, 1, 1, 0, 0, 3'b000, 0, 1, 32'h10,      32'h0,         1, 32'h40,        1, 32'h50,        0, 32'h0);
    step(0, 0, 1, 0, 0, 3'b000, 0, 1, 32'h10,        32'h0,         1, 32'h40,        1, 32'h50,        0, 32'h0);
    step(0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,         32'h0,         1, 32'h50,        0, 32'h54,        0, 32'h0);
    // Stalled misaligned JAL: no trap. Reserved funct3 and not-taken misaligned branch: no trap.
    step(0, 1, 0, 1, 0, 3'b000, 0, 0, 32'h2,         32'h0,         1, 32'h54,        1, 32'h56,        0, 32'h0);
    step(0, 0, 1, 0, 0, 3'b010, 1, 1, 32'h2,         32'h0,         1, 32'h54,        0, 32'h58,        0, 32'h0);
    step(0, 0, 1, 0, 0, 3'b001, 0, 1, 32'h6,         32'h0,         1, 32'h58,        0, 32'h5C,        0, 32'h0);
    // JALR to FFFF_FFFC, wrap to 0, then JALR beats JAL.
    step(0, 0, 0, 0, 1, 3'b000, 0, 0, 32'h0,         32'hFFFF_FFFC, 1, 32'h5C,        1, 32'hFFFF_FFFC, 0, 32'h0);
    step(0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,         32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         0, 32'h0);
    step(0, 0, 0, 1, 1, 3'b000, 0, 0, 32'h4,         32'h800,       1, 32'h0,         1, 32'h804,       0, 32'h0);
    step(0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,         32'h0,         1, 32'h804,       0, 32'h808,       0, 32'h0);
    // JALR clears bit 0, then a misaligned JALR traps.
    step(0, 0, 0, 0, 1, 3'b000, 0, 0, 32'h0,         32'h2001,      1, 32'h808,       1, 32'h2000,      0, 32'h0);
    step(0, 0, 0, 0, 1, 3'b000, 0, 0, 32'h0,         32'h2002,      1, 32'h2000,      1, 32'h2002,      0, 32'h0);
    for (int i = 0; i < 5; i++)
      step(0, i[0], 0, 1, 0, 3'b000, 0, 0, 32'h100,  32'h0,         1, 32'h2000,      0, 32'h2004,      1, 32'h2000);
    // Reset leaves TRAP.
    step(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,         32'h0,         1, 32'h2000,      0, 32'h2004,      1, 32'h2000);
    expect_counts(32'd0, 32'd0, 32'd0);
    step(0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,         32'h0,         1, 32'h0,         0, 32'h4,         0, 32'h0);
    // Counted sequence: 4 branches (3 taken), one stalled branch, 2 jumps, misaligned branch.
    step(0, 0, 1, 0, 0, 3'b000, 0, 1, 32'h8,         32'h0,         1, 32'h4,         1, 32'hC,         0, 32'h0);
    step(0, 0, 1, 0, 0, 3'b001, 0, 1, 32'h8,         32'h0,         1, 32'hC,         0, 32'h10,        0, 32'h0);
    step(0, 0, 1, 0, 0, 3'b100, 1, 0, 32'h10,        32'h0,         1, 32'h10,        1, 32'h20,        0, 32'h0);
    step(0, 1, 1, 0, 0, 3'b111, 0, 0, 32'h10,        32'h0,         1, 32'h20,        1, 32'h30,        0, 32'h0);
    step(0, 0, 1, 0, 0, 3'b111, 0, 0, 32'h10,        32'h0,         1, 32'h20,        1, 32'h30,        0, 32'h0);
    step(0, 0, 0, 1, 0, 3'b000, 0, 0, 32'h10,        32'h0,         1, 32'h30,        1, 32'h40,        0, 32'h0);
    step(0, 0, 0, 0, 1, 3'b000, 0, 0, 32'h1,         32'h100,       1, 32'h40,        1, 32'h100,       0, 32'h0);
    step(0, 0, 1, 0, 0, 3'b000, 0, 1, 32'h2,         32'h0,         1, 32'h100,       1, 32'h102,       0, 32'h0);
    expect_counts(32'd4, 32'd3, 32'd2);
    step(0, 0, 1, 0, 0, 3'b000, 0, 1, 32'h8,         32'h0,         1, 32'h100,       0, 32'h104,       1, 32'h100);
    expect_counts(32'd4, 32'd3, 32'd2);
    step(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,         32'h0,         1, 32'h100,       0, 32'h104,       1, 32'h100);
    expect_counts(32'd0, 32'd0, 32'd0);
    step(0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,         32'h0,         1, 32'h0,         0, 32'h4,         0, 32'h0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
